// File: rtl/flag_unit_pkg.sv
// Shared definitions for the condition-code register and its users (ALU, flag_unit).
package flag_unit_pkg;

    // Flag vector width and bit positions, {C, N, Z}
    localparam int unsigned CCR_W = 3;
    localparam int unsigned C_BIT = 2;
    localparam int unsigned N_BIT = 1;
    localparam int unsigned Z_BIT = 0;

    // carry_op encodings; 2'b11 is treated as no operation
    localparam logic [1:0] CARRY_NONE = 2'b00;
    localparam logic [1:0] CARRY_SETC = 2'b01;
    localparam logic [1:0] CARRY_CLRC = 2'b10;

    // jump_type encodings
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JZ   = 2'b01;
    localparam logic [1:0] JMP_JN   = 2'b10;
    localparam logic [1:0] JMP_JC   = 2'b11;

    // Shadow-copy FSM states
    typedef enum logic {
        SHD_EMPTY = 1'b0,
        SHD_HELD  = 1'b1
    } shd_state_e;

endpackage

// File: rtl/flag_shadow.sv
// One-deep shadow of the flag register for interrupt entry / RTI, with a sticky
// protocol-error flag for unmatched saves and restores.
module flag_shadow #(
    parameter int unsigned CCR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall,
    input  logic             i_int_save,
    input  logic             i_rti_restore,
    input  logic [CCR_W-1:0] i_ccr,
    output logic [CCR_W-1:0] o_shadow,
    output logic             o_held,
    output logic             o_seq_err
);
    import flag_unit_pkg::*;

    shd_state_e       r_state;
    shd_state_e       w_state_d;
    logic [CCR_W-1:0] r_shadow;
    logic             r_seq_err;
    logic             w_load;
    logic             w_err_set;

    // State register; reset discards the shadow immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SHD_EMPTY;
        end else if (!i_stall) begin
            r_state <= w_state_d;
        end
    end

    // Next state: save fills, restore empties, save+restore while held tail-chains
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            SHD_EMPTY: if (i_int_save) w_state_d = SHD_HELD;
            SHD_HELD:  if (i_rti_restore && !i_int_save) w_state_d = SHD_EMPTY;
            default:   w_state_d = SHD_EMPTY;
        endcase
    end

    // Outputs and event decode
    always_comb begin
        o_held    = (r_state == SHD_HELD);
        // Only the first save is captured; a nested save leaves the snapshot alone
        w_load    = i_int_save && (r_state == SHD_EMPTY);
        w_err_set = (i_int_save && !i_rti_restore && (r_state == SHD_HELD)) ||
                    (i_rti_restore && (r_state == SHD_EMPTY));
    end

    // Shadow snapshot takes the pre-update registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (!i_stall && w_load) begin
            r_shadow <= i_ccr;
        end
    end

    // Sticky sequencing error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_err <= 1'b0;
        end else if (!i_stall && w_err_set) begin
            r_seq_err <= 1'b1;
        end
    end

    assign o_shadow  = r_shadow;
    assign o_seq_err = r_seq_err;

endmodule

// File: rtl/flag_unit.sv
// Condition-code register: latches ALU flags, applies SETC/CLRC, resolves
// conditional jumps (clearing the tested flag) and saves/restores via a shadow.
module flag_unit #(
    parameter int unsigned CCR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CCR_W-1:0] alu_flags,
    input  logic             flag_wr_en,
    input  logic [1:0]       carry_op,
    input  logic [1:0]       jump_type,
    input  logic             jump_uncond,
    input  logic             int_save,
    input  logic             rti_restore,
    input  logic             stall,
    output logic [CCR_W-1:0] ccr,
    output logic             jump_taken,
    output logic             shadow_valid,
    output logic             seq_err
);
    import flag_unit_pkg::*;

    logic [CCR_W-1:0] r_ccr;
    logic [CCR_W-1:0] w_ccr_d;
    logic [CCR_W-1:0] w_shadow;
    logic             w_held;
    logic             w_restore;
    logic             w_cond_taken;

    assign w_restore = rti_restore && w_held;

    // Branch decision on the registered flags, not on this cycle's ALU output
    always_comb begin
        w_cond_taken = 1'b0;
        unique case (jump_type)
            JMP_JZ:  w_cond_taken = r_ccr[Z_BIT];
            JMP_JN:  w_cond_taken = r_ccr[N_BIT];
            JMP_JC:  w_cond_taken = r_ccr[C_BIT];
            default: w_cond_taken = 1'b0;
        endcase
        jump_taken = jump_uncond || w_cond_taken;
    end

    // Next flags: restore wins outright; otherwise ALU write, carry op, then jump clear
    always_comb begin
        w_ccr_d = r_ccr;
        if (w_restore) begin
            w_ccr_d = w_shadow;
        end else begin
            if (flag_wr_en) begin
                w_ccr_d = alu_flags;
            end
            if (carry_op == CARRY_SETC) begin
                w_ccr_d[C_BIT] = 1'b1;
            end else if (carry_op == CARRY_CLRC) begin
                w_ccr_d[C_BIT] = 1'b0;
            end
            // Taken conditional jump consumes its flag; unconditional jumps do not
            if (w_cond_taken) begin
                unique case (jump_type)
                    JMP_JZ:  w_ccr_d[Z_BIT] = 1'b0;
                    JMP_JN:  w_ccr_d[N_BIT] = 1'b0;
                    JMP_JC:  w_ccr_d[C_BIT] = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Flag register, frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ccr <= '0;
        end else if (!stall) begin
            r_ccr <= w_ccr_d;
        end
    end

    flag_shadow #(
        .CCR_W(CCR_W)
    ) u_shadow (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (stall),
        .i_int_save   (int_save),
        .i_rti_restore(rti_restore),
        .i_ccr        (r_ccr),
        .o_shadow     (w_shadow),
        .o_held       (w_held),
        .o_seq_err    (seq_err)
    );

    assign ccr          = r_ccr;
    assign shadow_valid = w_held;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: a driver issues one stimulus per cycle just after
// the rising edge and queues the expected mid-cycle outputs from a flag-level model;
// a monitor pops and compares at every falling edge.
module tb_flag_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] alu_flags = '0;
    logic       flag_wr_en = 1'b0;
    logic [1:0] carry_op = '0;
    logic [1:0] jump_type = '0;
    logic       jump_uncond = 1'b0;
    logic       int_save = 1'b0;
    logic       rti_restore = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] ccr;
    logic       jump_taken;
    logic       shadow_valid;
    logic       seq_err;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       rst;
        logic [2:0] alu;
        logic       wr;
        logic [1:0] cop;
        logic [1:0] jt;
        logic       ju;
        logic       isv;
        logic       rti;
        logic       stl;
    } stim_t;

    typedef struct packed {
        logic       jump;
        logic [2:0] ccr;
        logic       sv;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: flags, a list of saved flag sets (at most one), sticky error
    logic [2:0] m_ccr = '0;
    logic [2:0] m_saved[$];
    logic       m_err = 1'b0;

    flag_unit #(
        .CCR_W(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_flags   (alu_flags),
        .flag_wr_en  (flag_wr_en),
        .carry_op    (carry_op),
        .jump_type   (jump_type),
        .jump_uncond (jump_uncond),
        .int_save    (int_save),
        .rti_restore (rti_restore),
        .stall       (stall),
        .ccr         (ccr),
        .jump_taken  (jump_taken),
        .shadow_valid(shadow_valid),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input stim_t s);
        exp_t       e;
        logic [2:0] nxt;
        logic       held;
        logic       cond;
        int         b;
        @(posedge clk);
        #1;
        rst         = s.rst;
        alu_flags   = s.alu;
        flag_wr_en  = s.wr;
        carry_op    = s.cop;
        jump_type   = s.jt;
        jump_uncond = s.ju;
        int_save    = s.isv;
        rti_restore = s.rti;
        stall       = s.stl;
        if (s.rst) begin
            m_ccr = '0;
            m_saved.delete();
            m_err = 1'b0;
        end
        // JZ/JN/JC test flag 0/1/2 respectively
        b    = int'(s.jt) - 1;
        cond = (s.jt != 2'd0) && m_ccr[b];
        e.jump = s.ju || cond;
        e.ccr  = m_ccr;
        e.sv   = (m_saved.size() != 0);
        e.err  = m_err;
        exp_q.push_back(e);
        if (!s.rst && !s.stl) begin
            held = (m_saved.size() != 0);
            if (s.rti && held) begin
                nxt = m_saved[0];
                if (!s.isv) m_saved.delete();
            end else begin
                nxt = s.wr ? s.alu : m_ccr;
                if (s.cop == 2'd1) nxt[2] = 1'b1;
                if (s.cop == 2'd2) nxt[2] = 1'b0;
                if (cond) nxt[b] = 1'b0;
            end
            if (s.isv && !held) m_saved.push_back(m_ccr);
            if (s.isv && held && !s.rti) m_err = 1'b1;
            if (s.rti && !held) m_err = 1'b1;
            m_ccr = nxt;
        end
    endtask

    // Monitor: compare mid-cycle outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total = total + 4;
            if (jump_taken !== e.jump) begin
                bad = bad + 1;
                $display("FAIL jump_taken t=%0t got=%b want=%b", $time, jump_taken, e.jump);
            end
            if (ccr !== e.ccr) begin
                bad = bad + 1;
                $display("FAIL ccr t=%0t got=%b want=%b", $time, ccr, e.ccr);
            end
            if (shadow_valid !== e.sv) begin
                bad = bad + 1;
                $display("FAIL shadow_valid t=%0t got=%b want=%b", $time, shadow_valid, e.sv);
            end
            if (seq_err !== e.err) begin
                bad = bad + 1;
                $display("FAIL seq_err t=%0t got=%b want=%b", $time, seq_err, e.err);
            end
        end
    end

    initial begin
        stim_t s;
        // Reset state
        s = '0; s.rst = 1'b1; drive(s); drive(s);
        // Flag write then JZ consumes Z
        s = '0; s.wr = 1'b1; s.alu = 3'b101; drive(s);
        s = '0; s.jt = 2'd1; drive(s);
        s = '0; drive(s);
        // JC not taken, SETC, JC taken
        s = '0; s.wr = 1'b1; s.alu = 3'b000; drive(s);
        s = '0; s.jt = 2'd3; drive(s);
        s = '0; s.cop = 2'd1; drive(s);
        s = '0; s.jt = 2'd3; drive(s);
        s = '0; drive(s);
        // Write + CLRC + JN in one cycle
        s = '0; s.wr = 1'b1; s.alu = 3'b010; drive(s);
        s = '0; s.wr = 1'b1; s.alu = 3'b111; s.cop = 2'd2; s.jt = 2'd2; drive(s);
        s = '0; drive(s);
        // Save, overwrite, restore, jump on restored flags
        s = '0; s.wr = 1'b1; s.alu = 3'b011; drive(s);
        s = '0; s.isv = 1'b1; drive(s);
        s = '0; s.wr = 1'b1; s.alu = 3'b100; drive(s);
        s = '0; s.rti = 1'b1; drive(s);
        s = '0; s.jt = 2'd1; drive(s);
        s = '0; drive(s);
        // Nested save keeps first snapshot and flags error
        s = '0; s.wr = 1'b1; s.alu = 3'b011; drive(s);
        s = '0; s.isv = 1'b1; drive(s);
        s = '0; s.wr = 1'b1; s.alu = 3'b110; drive(s);
        s = '0; s.isv = 1'b1; drive(s);
        s = '0; s.rti = 1'b1; drive(s);
        s = '0; drive(s);
        // Restore while empty
        s = '0; s.rst = 1'b1; drive(s);
        s = '0; s.wr = 1'b1; s.alu = 3'b110; drive(s);
        s = '0; s.rti = 1'b1; drive(s);
        s = '0; drive(s);
        // Tail-chain: save and restore together while held
        s = '0; s.rst = 1'b1; drive(s);
        s = '0; s.wr = 1'b1; s.alu = 3'b101; drive(s);
        s = '0; s.isv = 1'b1; drive(s);
        s = '0; s.wr = 1'b1; s.alu = 3'b010; drive(s);
        s = '0; s.isv = 1'b1; s.rti = 1'b1; drive(s);
        s = '0; drive(s);
        // Stall freezes everything, then async reset mid-held
        s = '0; s.wr = 1'b1; s.alu = 3'b111; s.stl = 1'b1; s.isv = 1'b1; s.rti = 1'b1;
        drive(s);
        s = '0; s.rti = 1'b1; drive(s);
        s = '0; s.isv = 1'b1; drive(s);
        s = '0; s.rst = 1'b1; drive(s);
        s = '0; drive(s);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 39) == 0);
            s.alu = 3'($urandom_range(0, 7));
            s.wr  = 1'($urandom_range(0, 1));
            s.cop = 2'($urandom_range(0, 3));
            s.jt  = 2'($urandom_range(0, 3));
            s.ju  = ($urandom_range(0, 7) == 0);
            s.isv = ($urandom_range(0, 4) == 0);
            s.rti = ($urandom_range(0, 4) == 0);
            s.stl = ($urandom_range(0, 5) == 0);
            drive(s);
        end
        s = '0; drive(s);
        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
